// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle for one port of the data-memory arbiter.
// A requester uses the master modport; the arbiter uses the slave modport.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              lock;
    logic              gnt;
    logic              rvalid;

    modport master (
        output req, we, addr, wdata, lock,
        input  gnt, rvalid
    );

    modport slave (
        input  req, we, addr, wdata, lock,
        output gnt, rvalid
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with optional lock sharing a single-port data memory
// between two requesters; returns registered read data with per-port valid strobes.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     p0,
    dmem_arbiter_if.slave     p1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    logic last_q, last_d;
    logic owner_valid_q, owner_valid_d;
    logic owner_q, owner_d;
    logic rvalid0_q, rvalid0_d;
    logic rvalid1_q, rvalid1_d;
    logic gnt0, gnt1;
    logic [1:0] req;

    assign req = {p1.req, p0.req};

    always_comb begin
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        last_d        = last_q;
        owner_d       = owner_q;
        owner_valid_d = 1'b0;

        // Reset suppresses every grant so the memory sees no write during reset.
        if (!rst) begin
            if (owner_valid_q && req[owner_q]) begin
                gnt0 = ~owner_q;
                gnt1 = owner_q;
            end else if (req == 2'b01) begin
                gnt0 = 1'b1;
            end else if (req == 2'b10) begin
                gnt1 = 1'b1;
            end else if (req == 2'b11) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end
        end

        if (gnt0) begin
            last_d        = 1'b0;
            owner_d       = 1'b0;
            owner_valid_d = p0.lock;
        end else if (gnt1) begin
            last_d        = 1'b1;
            owner_d       = 1'b1;
            owner_valid_d = p1.lock;
        end

        rvalid0_d = gnt0 & ~p0.we;
        rvalid1_d = gnt1 & ~p1.we;

        if (gnt1) begin
            mem_addr  = p1.addr;
            mem_wdata = p1.wdata;
        end else begin
            mem_addr  = p0.addr;
            mem_wdata = p0.wdata;
        end
        mem_we = (gnt0 & p0.we) | (gnt1 & p1.we);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q        <= 1'b1;
            owner_valid_q <= 1'b0;
            owner_q       <= 1'b0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
            rdata         <= '0;
        end else begin
            last_q        <= last_d;
            owner_valid_q <= owner_valid_d;
            owner_q       <= owner_d;
            rvalid0_q     <= rvalid0_d;
            rvalid1_q     <= rvalid1_d;
            if (rvalid0_d || rvalid1_d) begin
                rdata <= mem_rdata;
            end
        end
    end

    assign p0.gnt    = gnt0;
    assign p1.gnt    = gnt1;
    assign p0.rvalid = rvalid0_q;
    assign p1.rvalid = rvalid1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected grants and read
// returns into queues; a negedge monitor pops and compares them.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rdata;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] mem [64];

    typedef struct {
        int          port;
        logic [15:0] data;
    } rd_t;

    int  gnt_q[$];
    rd_t rd_q[$];
    int  n_pass  = 0;
    int  n_total = 0;

    dmem_arbiter_if #(.ADDR_W(6), .DATA_W(16)) p0_if ();
    dmem_arbiter_if #(.ADDR_W(6), .DATA_W(16)) p1_if ();

    dmem_arbiter #(.ADDR_W(6), .DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0        (p0_if),
        .p1        (p1_if),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: asynchronous read, write on the falling edge.
    assign mem_rdata = mem[mem_addr];
    always @(negedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input int port, input logic [15:0] data);
        rd_t r;
        r.port = port;
        r.data = data;
        rd_q.push_back(r);
    endtask

    // Monitor: compare every grant and every read return against the queues.
    always @(negedge clk) begin
        int  exp_g;
        rd_t r;
        if (p0_if.gnt || p1_if.gnt) begin
            if (gnt_q.size() == 0) begin
                check("gnt_unexpected", {30'd0, p1_if.gnt, p0_if.gnt}, 32'd0);
            end else begin
                exp_g = gnt_q.pop_front();
                check("gnt_port", {30'd0, p1_if.gnt, p0_if.gnt}, (exp_g == 0) ? 32'd1 : 32'd2);
            end
        end
        if (p0_if.rvalid || p1_if.rvalid) begin
            if (rd_q.size() == 0) begin
                check("rvalid_unexpected", {30'd0, p1_if.rvalid, p0_if.rvalid}, 32'd0);
            end else begin
                r = rd_q.pop_front();
                check("rvalid_port", {30'd0, p1_if.rvalid, p0_if.rvalid},
                      (r.port == 0) ? 32'd1 : 32'd2);
                check("rdata", {16'd0, rdata}, {16'd0, r.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int c1;
        int g0;
        int g1;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        mem[1] = 16'h0011;
        mem[2] = 16'h0022;
        mem[7] = 16'h0707;

        p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.addr = '0; p0_if.wdata = '0; p0_if.lock = 1'b0;
        p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.addr = '0; p1_if.wdata = '0; p1_if.lock = 1'b0;

        // Reset with a pending write on port 0: nothing may reach the memory.
        rst = 1'b1;
        p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 6'd7; p0_if.wdata = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_gnt0", p0_if.gnt, 0);
            check("rst_gnt1", p1_if.gnt, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_rvalid0", p0_if.rvalid, 0);
            check("rst_rvalid1", p1_if.rvalid, 0);
            check("rst_rdata", rdata, 0);
        end
        rst = 1'b0;
        p0_if.req = 1'b0;
        step();
        check("rst_mem_untouched", mem[7], 16'h0707);

        // Single port 0: write then read back the same address.
        p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 6'd5; p0_if.wdata = 16'hBEEF;
        gnt_q.push_back(0);
        step();
        p0_if.we = 1'b0;
        gnt_q.push_back(0);
        push_rd(0, 16'hBEEF);
        step();
        p0_if.req = 1'b0;
        step();
        check("single_mem5", mem[5], 16'hBEEF);

        // Contention right after reset: port 0 first, then port 1.
        rst = 1'b1;
        step();
        rst = 1'b0;
        p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 6'd1;
        p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.addr = 6'd2;
        gnt_q.push_back(0); gnt_q.push_back(1);
        push_rd(0, 16'h0011); push_rd(1, 16'h0022);
        step();
        p0_if.req = 1'b0;
        step();
        p1_if.req = 1'b0;
        step();

        // Fairness: four writes per port, grants must alternate starting at port 0.
        for (int i = 0; i < 4; i++) begin
            gnt_q.push_back(0);
            gnt_q.push_back(1);
        end
        c0 = 0;
        c1 = 0;
        for (int cyc = 0; cyc < 20 && (c0 < 4 || c1 < 4); cyc++) begin
            p0_if.req = (c0 < 4); p0_if.we = 1'b1;
            p0_if.addr = 6'(16 + c0); p0_if.wdata = 16'(16'hA000 + c0);
            p1_if.req = (c1 < 4); p1_if.we = 1'b1;
            p1_if.addr = 6'(32 + c1); p1_if.wdata = 16'(16'hB000 + c1);
            @(negedge clk);
            g0 = int'(p0_if.gnt);
            g1 = int'(p1_if.gnt);
            step();
            c0 += g0;
            c1 += g1;
        end
        p0_if.req = 1'b0;
        p1_if.req = 1'b0;
        check("fair_done", c0 + c1, 8);
        step();
        for (int i = 0; i < 4; i++) begin
            check("fair_mem_p0", mem[16 + i], 16'hA000 + i);
            check("fair_mem_p1", mem[32 + i], 16'hB000 + i);
        end

        // Lock: port 1 holds the memory for three reads while port 0 waits.
        p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.lock = 1'b1; p1_if.addr = 6'd1;
        gnt_q.push_back(1); push_rd(1, 16'h0011);
        step();
        p1_if.addr = 6'd2;
        p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 6'd16;
        gnt_q.push_back(1); push_rd(1, 16'h0022);
        step();
        p1_if.addr = 6'd5; p1_if.lock = 1'b0;
        gnt_q.push_back(1); push_rd(1, 16'hBEEF);
        step();
        p1_if.req = 1'b0;
        gnt_q.push_back(0); push_rd(0, 16'hA000);
        step();
        p0_if.req = 1'b0;
        step();

        // Reset while port 1 owns the lock; its in-flight read must not return.
        p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.lock = 1'b1; p1_if.addr = 6'd1;
        gnt_q.push_back(1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 6'd2;
        step();
        check("midlock_rvalid1", p1_if.rvalid, 0);
        check("midlock_gnt0", p0_if.gnt, 0);
        check("midlock_gnt1", p1_if.gnt, 0);
        step();
        rst = 1'b0;
        gnt_q.push_back(0); push_rd(0, 16'h0022);
        step();
        p0_if.req = 1'b0;
        p1_if.lock = 1'b0;
        gnt_q.push_back(1); push_rd(1, 16'h0011);
        step();
        p1_if.req = 1'b0;

        repeat (3) step();
        check("gnt_queue_drained", gnt_q.size(), 0);
        check("rd_queue_drained", rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
